ebi_tx_sched: RTL

Transmit-side channel scheduler for the off-die EBI link. Arbitrates between the M1→M2 logical channels (ID_TEST, ID_CR), enforces per-channel receiver-buffer credits, and presents one message at a time to the EBI serializer. It sits between the on-die channel sources and the EBI send state machine. Credits return from the EBI credit-receive path.

---
 rtl/ebi_tx_sched.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ebi_tx_sched.sv
// EBI transmit channel scheduler: round-robin arbitration with per-channel receiver credits.
// Optional build macro EBI_TX_SCHED_CR_PRIO_EN gives ID_CR strict priority over the other channels.
package ebi_tx_sched_pkg;
  localparam int M1_M2_CHANNEL_NUM        = 2;
  // One bit wider than the channel count needs, so out-of-range credit ids can be flagged.
  localparam int M1_M2_CHANNEL_NUM_WIDTH  = 2;
  localparam int MAX_M1_M2_MESSAGE_LENGTH = 32;
  localparam int EBI_BUFFER_DEPTH         = 20;

  typedef enum logic [M1_M2_CHANNEL_NUM_WIDTH-1:0] {
    ID_TEST = 2'd0,
    ID_CR   = 2'd1
  } m1_m2_channel_id_t;
endpackage

module ebi_tx_sched
  import ebi_tx_sched_pkg::*;
#(
  parameter int CH_NUM = M1_M2_CHANNEL_NUM,
  parameter int MSG_W  = MAX_M1_M2_MESSAGE_LENGTH,
  parameter int DEPTH  = EBI_BUFFER_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CH_NUM-1:0]                    ch_valid_i,
  input  logic [CH_NUM-1:0][MSG_W-1:0]         ch_msg_i,
  output logic [CH_NUM-1:0]                    ch_ready_o,
  output logic                                 tx_valid_o,
  output logic [M1_M2_CHANNEL_NUM_WIDTH-1:0]   tx_id_o,
  output logic [MSG_W-1:0]                     tx_msg_o,
  input  logic                                 tx_ready_i,
  input  logic                                 crd_ret_valid_i,
  input  logic [M1_M2_CHANNEL_NUM_WIDTH-1:0]   crd_ret_id_i,
  output logic [CH_NUM-1:0][CNT_W-1:0]         crd_cnt_o,
  output logic                                 crd_err_o
);
  localparam int                ID_W    = M1_M2_CHANNEL_NUM_WIDTH;
  localparam int                PTR_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
`ifdef EBI_TX_SCHED_CR_PRIO_EN
  localparam int                CR_IDX  = int'(ID_CR);
`endif

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  state_e                       state_q, state_d;
  logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]              tx_id_q, tx_id_d;
  logic [MSG_W-1:0]             tx_msg_q, tx_msg_d;
  logic [CH_NUM-1:0][CNT_W-1:0] crd_q, crd_d;
  logic                         err_q, err_d;

  logic                         load_en;
  logic [CH_NUM-1:0]            elig;
  logic                         gnt_any;
  logic [PTR_W-1:0]             gnt_idx;
  logic                         gnt_upd_rr;

  always_comb begin
    elig = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      elig[k] = ch_valid_i[k] && (crd_q[k] != '0);
    end
  end

  // Search starts at rr_ptr_q and wraps; the first eligible channel wins.
  always_comb begin
    logic [CH_NUM-1:0] rr_elig;
    logic [PTR_W-1:0]  cidx;
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    gnt_any    = 1'b0;
    gnt_idx    = '0;
    gnt_upd_rr = 1'b0;
    rr_elig    = elig;
    cidx       = '0;
`ifdef EBI_TX_SCHED_CR_PRIO_EN
    rr_elig[CR_IDX] = 1'b0;
`endif
    for (int i = 0; i < CH_NUM; i++) begin
      cidx = PTR_W'((int'(rr_ptr_q) + i) % CH_NUM);
      if (!gnt_any && rr_elig[cidx]) begin
        gnt_any    = 1'b1;
        gnt_idx    = cidx;
        gnt_upd_rr = 1'b1;
      end
    end
`ifdef EBI_TX_SCHED_CR_PRIO_EN
    if (elig[CR_IDX]) begin
      gnt_any    = 1'b1;
      gnt_idx    = PTR_W'(CR_IDX);
      gnt_upd_rr = 1'b0;
    end
`endif
  end

  // Output slot: reloads whenever empty or when the serializer takes the held message.
  always_comb begin
    state_d    = state_q;
    tx_id_d    = tx_id_q;
    tx_msg_d   = tx_msg_q;
    rr_ptr_d   = rr_ptr_q;
    ch_ready_o = '0;
    load_en    = (state_q == ST_EMPTY) || (tx_valid_o && tx_ready_i);
    if (load_en) begin
      state_d = gnt_any ? ST_FULL : ST_EMPTY;
      if (gnt_any) begin
        ch_ready_o[gnt_idx] = !rst;
        tx_id_d             = ID_W'(gnt_idx);
        tx_msg_d            = ch_msg_i[gnt_idx];
        if (gnt_upd_rr) begin
          rr_ptr_d = PTR_W'((int'(gnt_idx) + 1) % CH_NUM);
        end
      end
    end
  end

  always_comb begin
    logic ret_ok;
    logic dec;
    logic inc;
    crd_d  = crd_q;
    err_d  = err_q;
    dec    = 1'b0;
    inc    = 1'b0;
    ret_ok = crd_ret_valid_i && (int'(crd_ret_id_i) < CH_NUM);
    if (crd_ret_valid_i && !ret_ok) begin
      err_d = 1'b1;
    end
    for (int k = 0; k < CH_NUM; k++) begin
      dec = load_en && gnt_any && (gnt_idx == PTR_W'(k));
      inc = ret_ok && (crd_ret_id_i == ID_W'(k));
      if (inc && !dec) begin
        if (crd_q[k] == DEPTH_C) err_d = 1'b1;
        else                     crd_d[k] = crd_q[k] + 1'b1;
      end else if (dec && !inc) begin
        crd_d[k] = crd_q[k] - 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      rr_ptr_q <= '0;
      tx_id_q  <= '0;
      tx_msg_q <= '0;
      crd_q    <= {CH_NUM{DEPTH_C}};
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      tx_id_q  <= tx_id_d;
      tx_msg_q <= tx_msg_d;
      crd_q    <= crd_d;
      err_q    <= err_d;
    end
  end

  assign tx_valid_o = (state_q == ST_FULL);
  assign tx_id_o    = tx_id_q;
  assign tx_msg_o   = tx_msg_q;
  assign crd_cnt_o  = crd_q;
  assign crd_err_o  = err_q;

endmodule
